// File: rtl/shift_unit_scheduler.sv
// Shared multi-cycle logical shifter: two requesters arbitrated round-robin,
// at most S bit positions shifted per cycle, result returned over valid/ready.
module shift_unit_scheduler #(
    parameter int N  = 8,
    parameter int S  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_data,
    input  logic [AW-1:0] req0_amt,
    input  logic          req0_dir,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_data,
    input  logic [AW-1:0] req1_amt,
    input  logic          req1_dir,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_id,
    output logic          busy
);

    localparam int RW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, next_state;
    logic          ptr;
    logic [RW-1:0] remaining;
    logic [N-1:0]  operand;
    logic          dir_q;
    logic          id_q;

    logic          grant_any;
    logic          grant_id;
    logic [AW-1:0] sel_amt;
    logic [N-1:0]  sel_data;
    logic          sel_dir;
    logic [RW-1:0] load_amt;
    logic [RW-1:0] step;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid && req1_valid) ? ptr : req1_valid;
        sel_amt   = grant_id ? req1_amt  : req0_amt;
        sel_data  = grant_id ? req1_data : req0_data;
        sel_dir   = grant_id ? req1_dir  : req0_dir;
        load_amt  = (32'(sel_amt) >= 32'(N)) ? RW'(N) : RW'(sel_amt);
        step      = (32'(remaining) < 32'(S)) ? remaining : RW'(S);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    next_state = (load_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (remaining == step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr       <= 1'b0;
            remaining <= '0;
            operand   <= '0;
            dir_q     <= 1'b0;
            id_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        operand   <= sel_data;
                        dir_q     <= sel_dir;
                        id_q      <= grant_id;
                        remaining <= load_amt;
                        ptr       <= ~grant_id;
                    end
                end
                SHIFT: begin
                    operand   <= dir_q ? (operand >> step) : (operand << step);
                    remaining <= remaining - step;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        res_valid  = (state == DONE);
        busy       = (state != IDLE);
        req0_ready = (state == IDLE) && grant_any && !grant_id;
        req1_ready = (state == IDLE) && grant_any && grant_id;
        res_data   = operand;
        res_id     = id_q;
    end

endmodule

// File: tb/tb_shift_unit_scheduler.sv
// Self-checking bench for shift_unit_scheduler: directed cases with literal
// expectations plus randomized traffic checked against a latency/result model.
module tb_shift_unit_scheduler;

    localparam int N  = 8;
    localparam int S  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [N-1:0]  req0_data = '0, req1_data = '0;
    logic [AW-1:0] req0_amt = '0, req1_amt = '0;
    logic          req0_dir = 1'b0, req1_dir = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [N-1:0]  res_data;
    logic          res_id;
    logic          busy;

    shift_unit_scheduler #(.N(N), .S(S), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_dir(req1_dir),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: idle / working (result due at a known cycle) / holding result.
    int          cyc = 0;
    bit          check_en = 1'b0;
    int          m_phase = 0;
    int          m_vc = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    logic [N-1:0] m_res = '0;

    always @(negedge clk) begin
        int e0, e1, k, g;
        logic [N-1:0] d;
        cyc++;
        if (check_en) begin
            if (m_phase == 1 && cyc >= m_vc) m_phase = 2;
            e0 = 0;
            e1 = 0;
            if (m_phase == 0) begin
                e0 = (req0_valid && (!req1_valid || m_ptr == 0)) ? 1 : 0;
                e1 = (req1_valid && (!req0_valid || m_ptr == 1)) ? 1 : 0;
            end
            chk("m_ready0", req0_ready, e0);
            chk("m_ready1", req1_ready, e1);
            chk("m_valid", res_valid, (m_phase == 2) ? 1 : 0);
            chk("m_busy", busy, (m_phase != 0) ? 1 : 0);
            if (m_phase == 2) begin
                chk("m_data", res_data, m_res);
                chk("m_id", res_id, m_id);
            end
            if (!reset_n) begin
                m_phase = 0;
                m_ptr = 0;
            end else if (m_phase == 0 && (e0 != 0 || e1 != 0)) begin
                g = (e1 != 0) ? 1 : 0;
                k = (g != 0) ? int'(req1_amt) : int'(req0_amt);
                if (k > N) k = N;
                d = (g != 0) ? req1_data : req0_data;
                if ((g != 0) ? req1_dir : req0_dir) m_res = d >> k;
                else m_res = d << k;
                m_id = g;
                m_ptr = 1 - g;
                m_vc = cyc + 1 + (k + S - 1) / S;
                m_phase = 1;
            end else if (m_phase == 2 && res_ready) begin
                m_phase = 0;
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int side, input logic [N-1:0] d, input logic [AW-1:0] a,
                      input logic dr, input logic [N-1:0] exp_d, input int exp_lat,
                      input string name);
        int lat;
        res_ready = 1'b1;
        if (side == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_dir = dr;
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_dir = dr;
        end
        #1;
        chk({name, "_acc"}, (side == 0) ? req0_ready : req1_ready, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            lat = i;
            if (res_valid) break;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_data"}, res_data, exp_d);
        chk({name, "_id"}, res_id, side);
        step_cycle();
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        int ids[$];
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_en = 1'b1;
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        op(0, 8'hB7, 4'd5, 1'b0, 8'hE0, 3, "left");
        op(1, 8'hFF, 4'd7, 1'b1, 8'h01, 4, "right");
        op(0, 8'h5A, 4'd0, 1'b0, 8'h5A, 1, "zero");
        op(1, 8'hFF, 4'd12, 1'b0, 8'h00, 4, "sat");

        // Backpressure: result must hold while the consumer stalls.
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h81; req0_amt = 4'd2; req0_dir = 1'b1;
        step_cycle();
        req0_valid = 1'b0;
        for (int i = 0; i < 10 && !res_valid; i++) step_cycle();
        chk("bp_valid", res_valid, 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_cycle();
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_data", res_data, 8'h20);
            chk("bp_hold_id", res_id, 0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        step_cycle();
        chk("bp_release", busy, 0);

        // Reset in the middle of a shift abandons it and clears the pointer.
        req0_valid = 1'b1; req0_data = 8'hFF; req0_amt = 4'd7; req0_dir = 1'b1;
        step_cycle();
        req0_valid = 1'b0;
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        step_cycle();
        reset_n = 1'b1;
        chk("mid_valid", res_valid, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_data", res_data, 0);
        chk("mid_id", res_id, 0);
        req0_amt = 4'd0; req1_amt = 4'd0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mid_ptr0", req0_ready, 1);
        chk("mid_ptr1", req1_ready, 0);
        step_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step_cycle();

        // Arbitration from reset with both requesters always pending.
        reset_n = 1'b0;
        step_cycle();
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h3C; req0_amt = 4'd1; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hC3; req1_amt = 4'd1; req1_dir = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 60 && ids.size() < 4; i++) begin
            if (res_valid && res_ready) ids.push_back(int'(res_id));
            step_cycle();
        end
        chk("arb_count", ids.size(), 4);
        for (int i = 0; i < ids.size(); i++) chk("arb_id", ids[i], i % 2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) step_cycle();

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 500; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data = N'($urandom);
            req1_data = N'($urandom);
            req0_amt = AW'($urandom_range(0, 15));
            req1_amt = AW'($urandom_range(0, 15));
            req0_dir = $urandom_range(0, 1) != 0;
            req1_dir = $urandom_range(0, 1) != 0;
            res_ready = ($urandom_range(0, 9) < 7);
            reset_n = ($urandom_range(0, 99) != 0);
            step_cycle();
        end
        reset_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (10) step_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
